// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the load/store access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } access_size_t;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} mau_state_t;

  localparam logic [3:0] LANE_MASK_BYTE = 4'b0001;
  localparam logic [3:0] LANE_MASK_HALF = 4'b0011;
  localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

  // Byte lanes touched by an access, already shifted to its offset.
  function automatic logic [3:0] lane_mask(access_size_t size, logic [1:0] offset);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = LANE_MASK_BYTE;
      SIZE_HALF: m = LANE_MASK_HALF;
      SIZE_WORD: m = LANE_MASK_WORD;
      default:   m = 4'b0000;
    endcase
    return m << offset;
  endfunction

  function automatic logic is_bad_access(access_size_t size, logic [1:0] offset);
    case (size)
      SIZE_HALF: return offset[0];
      SIZE_WORD: return offset != 2'b00;
      SIZE_RSVD: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: load extract/extend and sub-word store merge.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        signed_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  access_size_t size;
  logic [31:0]  shifted;
  logic [31:0]  st_shifted;
  logic [3:0]   mask;

  assign size = access_size_t'(size_i);

  always_comb begin
    shifted    = rd_word_i >> {offset_i, 3'b000};
    st_shifted = st_data_i << {offset_i, 3'b000};
    mask       = lane_mask(size, offset_i);

    case (size)
      SIZE_BYTE: load_data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default:   load_data_o = rd_word_i;
    endcase

    merged_o = rd_word_i;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) merged_o[8*k +: 8] = st_shifted[8*k +: 8];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator with read-modify-write for sub-word stores.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 10
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic             reqWrite,
  input  logic [1:0]       reqSize,
  input  logic             reqSigned,
  input  logic [31:0]      reqAddress,
  input  logic [31:0]      reqWriteData,
  output logic             respValid,
  input  logic             respReady,
  output logic [31:0]      respData,
  output logic             respError,
  output logic [DEPTH-1:0] memAddressRead,
  output logic [DEPTH-1:0] memAddressWrite,
  output logic             memEnableRead,
  output logic             memEnableWrite,
  output logic [WIDTH-1:0] memDataIn,
  input  logic [WIDTH-1:0] memDataOut
);

  mau_state_t       state_q, state_d;
  logic [DEPTH-1:0] addr_q, addr_d;
  logic [1:0]       offset_q, offset_d;
  access_size_t     size_q, size_d;
  logic             signed_q, signed_d;
  logic             write_q, write_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      merged_q, merged_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic             resp_error_q, resp_error_d;

  logic [31:0]      load_data;
  logic [31:0]      merged_word;
  access_size_t     req_size;

  // Upper address bits alias onto the same words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^reqAddress[31:DEPTH+2];

  assign req_size = access_size_t'(reqSize);

  mem_lane_align u_align (
    .size_i      (size_q),
    .offset_i    (offset_q),
    .signed_i    (signed_q),
    .rd_word_i   (memDataOut),
    .st_data_i   (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged_word)
  );

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    offset_d       = offset_q;
    size_d         = size_q;
    signed_d       = signed_q;
    write_d        = write_q;
    wdata_d        = wdata_q;
    merged_d       = merged_q;
    resp_data_d    = resp_data_q;
    resp_error_d   = resp_error_q;
    memEnableRead  = 1'b0;
    memEnableWrite = 1'b0;
    memDataIn      = '0;

    case (state_q)
      IDLE: begin
        if (reqValid) begin
          addr_d       = reqAddress[DEPTH+1:2];
          offset_d     = reqAddress[1:0];
          size_d       = req_size;
          signed_d     = reqSigned;
          write_d      = reqWrite;
          wdata_d      = reqWriteData;
          resp_data_d  = '0;
          resp_error_d = is_bad_access(req_size, reqAddress[1:0]);
          state_d      = resp_error_d ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (write_q && size_q == SIZE_WORD) begin
          memEnableWrite = 1'b1;
          memDataIn      = wdata_q;
          state_d        = RESP;
        end else if (write_q) begin
          memEnableRead = 1'b1;
          merged_d      = merged_word;
          state_d       = WRITE;
        end else begin
          memEnableRead = 1'b1;
          resp_data_d   = load_data;
          state_d       = RESP;
        end
      end
      WRITE: begin
        memEnableWrite = 1'b1;
        memDataIn      = merged_q;
        state_d        = RESP;
      end
      RESP: begin
        if (respReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      offset_q     <= '0;
      size_q       <= SIZE_BYTE;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      merged_q     <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      offset_q     <= offset_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      merged_q     <= merged_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads 0.
  assign reqReady        = (state_q == IDLE) && resetN;
  assign respValid       = (state_q == RESP);
  assign respData        = respValid ? resp_data_q : '0;
  assign respError       = respValid & resp_error_q;
  assign memAddressRead  = addr_q;
  assign memAddressWrite = addr_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store initiator that sits between the pipeline MEM stage and the generic word-addressed data memory. It accepts byte, halfword and word load/store requests on a valid/ready handshake and drives the memory's separate read-address and write-address ports. Sub-word stores are handled by read-modify-write. It returns aligned, sign- or zero-extended load data and an error flag on a valid/ready response channel.

Parameters:
WIDTH, 32, memory word width in bits; fixed at 32 for byte-lane logic.
DEPTH, 10, word-address bits driven to the memory.

Ports:
clock  in  1  system clock, rising edge.
resetN  in  1  asynchronous, active-low reset.
reqValid  in  1  request present.
reqReady  out  1  unit can accept a request.
reqWrite  in  1  1 = store, 0 = load.
reqSize  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
reqSigned  in  1  sign-extend load data. Ignored for stores.
reqAddress  in  32  byte address.
reqWriteData  in  32  store data, right-aligned.
respValid  out  1  response present.
respReady  in  1  consumer takes the response.
respData  out  32  load result. 0 for stores and errors.
respError  out  1  misaligned access or reserved size.
memAddressRead  out  DEPTH  memory read word address.
memAddressWrite  out  DEPTH  memory write word address.
memEnableRead  out  1  memory read enable.
memEnableWrite  out  1  memory write enable.
memDataIn  out  WIDTH  word written to memory.
memDataOut  in  WIDTH  memory read data (combinational, same cycle).

Behaviour:
- Reset (async, resetN=0): state IDLE. All outputs 0, except reqReady, which is 1 after reset release. memEnableWrite drops immediately, so a pending write does not occur.
- Word address = reqAddress[DEPTH+1:2]. Upper address bits are ignored (aliasing). Byte lanes are little-endian: lane k = bits 8k+7:8k, selected by addr[1:0].
- Misaligned accesses: halfword with addr[0]=1, word with addr[1:0]≠0, and size 11 are errors. They never assert a memory enable.
- Handshake:
  - Accept when reqValid && reqReady. reqReady = (state==IDLE). Request fields are registered on accept.
  - A response is held stable while respValid && !respReady.
  - Only one request is in flight at a time.
- States:
  - IDLE: on accept, go to RESP with respError=1 if the request is an error; otherwise go to ACCESS.
  - ACCESS:
    - memEnableRead=1 for loads and partial stores. memEnableWrite=1 for word stores.
    - Load: extract lane, extend, register into respData → RESP.
    - Word store: memDataIn=reqWriteData → RESP.
    - Partial store: merge store lanes into memDataOut, register the merged word → WRITE.
  - WRITE: memEnableWrite=1, memDataIn=merged word → RESP.
  - RESP: respValid=1. On respReady → IDLE.
- Latency (accept edge to respValid): load 2 cycles, word store 2, partial store 3, error 1.
- Enable timing: memory enables are decoded from the state register only. memAddressRead = memAddressWrite = registered word address.
- Merge rule: only the addressed byte/halfword lanes are replaced; other lanes keep the read value.
- Simultaneous events: a new reqValid during RESP is not accepted. It is taken in the following IDLE cycle.

Decomposition:
- Package mem_access_pkg holds:
  - typedef enum access_size_t {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD}.
  - typedef enum mau_state_t {IDLE, ACCESS, WRITE, RESP}.
  - Lane-mask constants.
- Sub-module mem_lane_align: purely combinational. It performs load extraction/extension and store merging from (size, offset, signed, word, storeData).

Test Plan:
- Word store 0xDEADBEEF at 0x10, then word load 0x10 → memEnableWrite for 1 cycle at word address 4 with data DEADBEEF; load respData=0xDEADBEEF 2 cycles after accept, respError=0.
- Byte store 0xAB at 0x13 over DEADBEEF → read then write of 0xABADBEEF; signed byte load 0x13 → 0xFFFFFFAB; unsigned → 0x000000AB.
- Halfword store 0x8001 at 0x12, signed halfword load 0x12 → 0xFFFF8001; unsigned → 0x00008001; lower lanes unchanged (BEEF).
- Halfword load at 0x11 and size 11 at 0x20 → respValid 1 cycle after accept, respError=1, respData=0, memEnableRead/Write never asserted.
- respReady held 0 for 5 cycles → respValid/respData stable, reqReady=0 throughout; on respReady, next cycle IDLE with reqReady=1.
- resetN asserted while in WRITE of a byte store → memEnableWrite falls immediately, target word unchanged on later load, all outputs 0 during reset.
